my_bus_slave: RTL and testbench

MY_BUS_SLAVE -- requirements
Module: my_bus_slave

---
 rtl/my_bus_slave.sv | 137 +++++++++++++
 tb/tb_my_bus_slave.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/my_bus_slave.sv
// Register-file bus slave: single and burst reads/writes over a DEPTH-word window
// starting at BASE_ADDR, with clear, error reporting and burst abort on sel drop.
module my_bus_slave #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 8,
  parameter int                DEPTH     = 16,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 8'h10,
  parameter int                BURST_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
  input  logic [2:0]        mode,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = $clog2(BURST_LEN);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(BASE_ADDR) + (ADDR_W+1)'(DEPTH);
  localparam logic [CW-1:0]   LAST  = CW'(BURST_LEN - 1);

  localparam logic [2:0] M_NOP = 3'b000;
  localparam logic [2:0] M_WR  = 3'b001;
  localparam logic [2:0] M_RD  = 3'b010;
  localparam logic [2:0] M_BWR = 3'b011;
  localparam logic [2:0] M_BRD = 3'b100;
  localparam logic [2:0] M_CLR = 3'b101;

  typedef enum logic [1:0] {IDLE, BWR, BRD} state_t;

  state_t            state, state_nx;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [IW-1:0]     ptr, ptr_nx;
  logic [CW-1:0]     beat, beat_nx;

  logic              in_range;
  logic [IW-1:0]     idx;
  logic              we, re, clr, ack_nx, err_nx;
  logic [IW-1:0]     wa, ra;

  assign in_range = ({1'b0, addr} >= {1'b0, BASE_ADDR}) && ({1'b0, addr} < LIMIT);
  assign idx      = IW'(addr - BASE_ADDR);
  assign busy     = (state != IDLE);

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    beat_nx  = beat;
    we       = 1'b0;
    re       = 1'b0;
    clr      = 1'b0;
    wa       = ptr;
    ra       = ptr;
    ack_nx   = 1'b0;
    err_nx   = 1'b0;
    case (state)
      IDLE: begin
        if (sel) begin
          case (mode)
            M_NOP: ;
            M_CLR: begin
              clr    = 1'b1;
              ack_nx = 1'b1;
            end
            M_WR, M_RD, M_BWR, M_BRD: begin
              if (!in_range) begin
                err_nx = 1'b1;
              end else begin
                // Command cycle carries beat 0; bursts continue from idx+1.
                wa      = idx;
                ra      = idx;
                ptr_nx  = idx + IW'(1);
                beat_nx = CW'(1);
                case (mode)
                  M_WR:  begin we = 1'b1; ack_nx = 1'b1; end
                  M_RD:  re = 1'b1;
                  M_BWR: begin we = 1'b1; ack_nx = 1'b1; state_nx = BWR; end
                  default: begin re = 1'b1; state_nx = BRD; end
                endcase
              end
            end
            default: err_nx = 1'b1;
          endcase
        end
      end
      default: begin
        if (!sel) begin
          err_nx   = 1'b1;
          state_nx = IDLE;
        end else begin
          if (state == BWR) begin
            we     = 1'b1;
            ack_nx = 1'b1;
          end else begin
            re = 1'b1;
          end
          ptr_nx = ptr + IW'(1);
          if (beat == LAST) state_nx = IDLE;
          else              beat_nx  = beat + CW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      ptr    <= '0;
      beat   <= '0;
      rdata  <= '0;
      rvalid <= 1'b0;
      ack    <= 1'b0;
      err    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state  <= state_nx;
      ptr    <= ptr_nx;
      beat   <= beat_nx;
      rvalid <= re;
      ack    <= ack_nx;
      err    <= err_nx;
      if (re) rdata <= mem[ra];
      if (clr) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
        mem[wa] <= data;
      end
    end
  end

endmodule

// File: tb/tb_my_bus_slave.sv
// Bench for my_bus_slave: transaction-level model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic with reset pulses.
module tb_my_bus_slave;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sel = 1'b0;
  logic [2:0] mode = 3'b000;
  logic [7:0] addr = 8'h00;
  logic [7:0] data = 8'h00;
  logic [7:0] rdata;
  logic       rvalid, ack, err, busy;

  int vectors = 0;
  int miscompares = 0;

  my_bus_slave dut (
    .clk(clk), .rst(rst), .sel(sel), .mode(mode), .addr(addr), .data(data),
    .rdata(rdata), .rvalid(rvalid), .ack(ack), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Model: register contents plus "how many burst beats remain, of which kind, where".
  logic [7:0] mm [16];
  logic [7:0] exp_rdata = 8'h00;
  logic       exp_rvalid = 1'b0, exp_ack = 1'b0, exp_err = 1'b0, exp_busy = 1'b0;
  int         left = 0;
  int         nidx = 0;
  bit         bwrite = 1'b0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 16; i++) mm[i] = 8'h00;
      exp_rdata = 8'h00; exp_rvalid = 0; exp_ack = 0; exp_err = 0; exp_busy = 0;
      left = 0;
    end else begin
      int ai, wi;
      bit inr;
      exp_ack = 0; exp_err = 0; exp_rvalid = 0;
      ai  = int'(addr);
      inr = (ai >= 16) && (ai < 32);
      wi  = (ai - 16) & 15;
      if (left > 0) begin
        if (!sel) begin
          exp_err = 1; left = 0;
        end else begin
          if (bwrite) begin mm[nidx] = data; exp_ack = 1; end
          else begin exp_rdata = mm[nidx]; exp_rvalid = 1; end
          nidx = (nidx + 1) % 16;
          left = left - 1;
        end
      end else if (sel) begin
        case (mode)
          3'd0: ;
          3'd5: begin for (int i = 0; i < 16; i++) mm[i] = 8'h00; exp_ack = 1; end
          3'd1, 3'd3: begin
            if (!inr) exp_err = 1;
            else begin
              mm[wi] = data; exp_ack = 1;
              if (mode == 3'd3) begin left = 3; nidx = (wi + 1) % 16; bwrite = 1; end
            end
          end
          3'd2, 3'd4: begin
            if (!inr) exp_err = 1;
            else begin
              exp_rdata = mm[wi]; exp_rvalid = 1;
              if (mode == 3'd4) begin left = 3; nidx = (wi + 1) % 16; bwrite = 0; end
            end
          end
          default: exp_err = 1;
        endcase
      end
      exp_busy = (left > 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model.rdata", 32'(rdata), 32'(exp_rdata));
    chk("model.rvalid", 32'(rvalid), 32'(exp_rvalid));
    chk("model.ack", 32'(ack), 32'(exp_ack));
    chk("model.err", 32'(err), 32'(exp_err));
    chk("model.busy", 32'(busy), 32'(exp_busy));
    chk("exclusive", 32'(32'(ack) + 32'(rvalid) + 32'(err) > 1), 32'd0);
  end

  task automatic drive(input logic s, input logic [2:0] m, input logic [7:0] a, input logic [7:0] d);
    sel = s; mode = m; addr = a; data = d;
    @(negedge clk);
  endtask

  initial begin
    logic [2:0] md;
    logic [7:0] bdat [4];
    bdat[0] = 8'h11; bdat[1] = 8'h22; bdat[2] = 8'h33; bdat[3] = 8'h44;

    repeat (2) @(negedge clk);
    chk("reset.rvalid", 32'(rvalid), 32'd0);
    chk("reset.busy", 32'(busy), 32'd0);
    rst = 1'b1;
    drive(0, 3'd0, 8'h00, 8'h00);

    // Read of a freshly reset word
    drive(1, 3'd2, 8'h15, 8'h00);
    chk("rd15.rvalid", 32'(rvalid), 32'd1);
    chk("rd15.rdata", 32'(rdata), 32'h00);

    // Single write then read back
    drive(1, 3'd1, 8'h12, 8'hA5);
    chk("wr12.ack", 32'(ack), 32'd1);
    drive(1, 3'd2, 8'h12, 8'h00);
    chk("rd12.ack", 32'(ack), 32'd0);
    chk("rd12.rdata", 32'(rdata), 32'hA5);

    // Out of range write and illegal mode
    drive(1, 3'd1, 8'h20, 8'h5A);
    chk("wr20.err", 32'(err), 32'd1);
    chk("wr20.ack", 32'(ack), 32'd0);
    drive(1, 3'd7, 8'h12, 8'h5A);
    chk("ill.err", 32'(err), 32'd1);
    drive(1, 3'd2, 8'h12, 8'h00);
    chk("rd12b.rdata", 32'(rdata), 32'hA5);

    // Wrapping burst write, then burst read back
    drive(1, 3'd3, 8'h1E, bdat[0]);
    for (int k = 1; k < 4; k++) begin
      chk("bwr.busy", 32'(busy), 32'd1);
      drive(1, 3'd0, 8'h00, bdat[k]);
      chk("bwr.ack", 32'(ack), 32'd1);
    end
    chk("bwr.busy_end", 32'(busy), 32'd0);
    drive(1, 3'd4, 8'h1E, 8'h00);
    for (int k = 0; k < 4; k++) begin
      chk("brd.rvalid", 32'(rvalid), 32'd1);
      chk("brd.rdata", 32'(rdata), 32'(bdat[k]));
      chk("brd.busy", 32'(busy), (k < 3) ? 32'd1 : 32'd0);
      if (k < 3) drive(1, 3'd0, 8'h00, 8'h00);
    end
    drive(1, 3'd2, 8'h11, 8'h00);
    chk("rd11.rdata", 32'(rdata), 32'h44);

    // Burst read aborted by sel drop before the third beat
    drive(1, 3'd4, 8'h10, 8'h00);
    chk("abort.b0", 32'(rdata), 32'h33);
    drive(1, 3'd0, 8'h00, 8'h00);
    chk("abort.b1", 32'(rdata), 32'h44);
    chk("abort.v1", 32'(rvalid), 32'd1);
    drive(0, 3'd0, 8'h00, 8'h00);
    chk("abort.err", 32'(err), 32'd1);
    chk("abort.rvalid", 32'(rvalid), 32'd0);
    chk("abort.busy", 32'(busy), 32'd0);
    drive(1, 3'd1, 8'h13, 8'h77);
    chk("abort.next_ack", 32'(ack), 32'd1);

    // Reset asserted during burst write beat 2
    drive(1, 3'd3, 8'h10, 8'h01);
    drive(1, 3'd0, 8'h00, 8'h02);
    data = 8'h03;
    #2 rst = 1'b0;
    #1;
    chk("rstmid.ack", 32'(ack), 32'd0);
    chk("rstmid.busy", 32'(busy), 32'd0);
    chk("rstmid.rdata", 32'(rdata), 32'h00);
    @(negedge clk);
    sel = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rstmid.err", 32'(err), 32'd0);
    drive(1, 3'd2, 8'h10, 8'h00);
    chk("rstmid.w0", 32'(rdata), 32'h00);
    drive(1, 3'd2, 8'h13, 8'h00);
    chk("rstmid.w3", 32'(rdata), 32'h00);

    // Randomized traffic, including occasional asynchronous reset pulses
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b0;
        #2 rst = 1'b1;
      end
      if ($urandom_range(0, 4) == 0) md = 3'($urandom_range(0, 7));
      else if ($urandom_range(0, 30) == 0) md = 3'd5;
      else md = 3'($urandom_range(1, 4));
      drive(($urandom_range(0, 9) != 0), md, 8'($urandom_range(8'h0C, 8'h24)), 8'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
